// File: rtl/mem_ctrl_if.sv
// Bundles the fetch port, the LSU port and the byte-wide RAM bus of mem_ctrl.
// The controller uses the slave view; the clients and the RAM use the master view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [1:0]        inst_stat;
  logic [ADDR_W-1:0] inst_done_addr;
  logic [DATA_W-1:0] inst_data;

  logic              data_req;
  logic              data_we;
  logic [1:0]        data_len;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [1:0]        data_stat;
  logic [DATA_W-1:0] data_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport master (
    output inst_req, inst_addr,
    output data_req, data_we, data_len, data_addr, data_wdata,
    output mem_din,
    input  inst_stat, inst_done_addr, inst_data,
    input  data_stat, data_rdata,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_we, data_len, data_addr, data_wdata,
    input  mem_din,
    output inst_stat, inst_done_addr, inst_data,
    output data_stat, data_rdata,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single owner of the byte-wide RAM bus: serialises fetch words and LSU 1/2/4-byte
// accesses into byte cycles, assembling read data little-endian.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [1:0] STAT_IDLE    = 2'd0;
  localparam logic [1:0] STAT_BUSY    = 2'd1;
  localparam logic [1:0] STAT_HANDLED = 2'd2;

  state_t            state, state_nxt;
  logic              last_inst;
  logic              cli_inst;
  logic              grant_any, grant_inst;
  logic              last_wr, last_rd;
  logic [2:0]        cnt;
  logic [2:0]        n_l;
  logic [1:0]        rd_idx;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] acc, acc_nxt;

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                 input logic [1:0] idx,
                                                 input logic [7:0] b);
    logic [DATA_W-1:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // On contention the client not granted last time wins; last_inst resets to 1 so data goes first.
  assign grant_any  = bus.inst_req | bus.data_req;
  assign grant_inst = bus.inst_req & (~bus.data_req | ~last_inst);

  // RAM read data lags the address by one cycle, so cycle k+1 carries byte k-1.
  assign rd_idx  = 2'(cnt - 3'd2);
  assign acc_nxt = put_byte(acc, rd_idx, bus.mem_din);
  assign last_wr = (cnt == n_l);
  assign last_rd = (cnt == n_l + 3'd1);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          if (!grant_inst && bus.data_we) state_nxt = S_WRITE;
          else                            state_nxt = S_READ;
        end
      end
      S_READ:  if (last_rd) state_nxt = S_DONE;
      S_WRITE: if (last_wr) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latched transaction operands and read assembly buffer
  always_ff @(posedge clk) begin
    if (state == S_IDLE && grant_any) begin
      acc <= '0;
      if (grant_inst) begin
        addr_l <= bus.inst_addr;
        n_l    <= 3'd4;
      end else begin
        addr_l  <= bus.data_addr;
        n_l     <= len_bytes(bus.data_len);
        wdata_l <= bus.data_wdata;
      end
    end else if (state == S_READ && cnt >= 3'd2) begin
      acc <= acc_nxt;
    end
  end

  // Registered client status and RAM bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.inst_stat      <= STAT_IDLE;
      bus.data_stat      <= STAT_IDLE;
      bus.inst_done_addr <= '0;
      bus.inst_data      <= '0;
      bus.data_rdata     <= '0;
      bus.mem_a          <= '0;
      bus.mem_dout       <= '0;
      bus.mem_wr         <= 1'b0;
      last_inst          <= 1'b1;
      cli_inst           <= 1'b0;
      cnt                <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cli_inst  <= grant_inst;
            last_inst <= grant_inst;
            cnt       <= 3'd1;
            if (grant_inst) begin
              bus.mem_a     <= bus.inst_addr;
              bus.inst_stat <= STAT_BUSY;
            end else begin
              bus.mem_a     <= bus.data_addr;
              bus.mem_wr    <= bus.data_we;
              bus.data_stat <= STAT_BUSY;
              if (bus.data_we) bus.mem_dout <= bus.data_wdata[7:0];
            end
          end
        end
        S_READ: begin
          cnt <= cnt + 3'd1;
          if (cnt < n_l) bus.mem_a <= addr_l + ADDR_W'(cnt);
          if (last_rd) begin
            bus.mem_a <= '0;
            if (cli_inst) begin
              bus.inst_stat      <= STAT_HANDLED;
              bus.inst_data      <= acc_nxt;
              bus.inst_done_addr <= addr_l;
            end else begin
              bus.data_stat  <= STAT_HANDLED;
              bus.data_rdata <= acc_nxt;
            end
          end
        end
        S_WRITE: begin
          cnt <= cnt + 3'd1;
          if (last_wr) begin
            bus.mem_wr    <= 1'b0;
            bus.mem_a     <= '0;
            bus.data_stat <= STAT_HANDLED;
          end else begin
            bus.mem_a    <= addr_l + ADDR_W'(cnt);
            bus.mem_dout <= get_byte(wdata_l, cnt[1:0]);
          end
        end
        S_DONE: begin
          bus.inst_stat <= STAT_IDLE;
          bus.data_stat <= STAT_IDLE;
          bus.mem_wr    <= 1'b0;
          bus.mem_a     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small read-only RAM image and a write log.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   wr_cnt;
  int   wr_base;
  logic [31:0] last_wa;
  logic [7:0]  last_wd;

  mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_img(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h13;
      32'h0000_0101: return 8'h05;
      32'h0000_0200: return 8'hEF;
      32'h0000_0201: return 8'hBE;
      32'h0000_0202: return 8'hAD;
      32'h0000_0203: return 8'hDE;
      32'hFFFF_FFFF: return 8'h34;
      32'h0000_0000: return 8'h12;
      default:       return 8'h00;
    endcase
  endfunction

  // RAM: one-cycle read latency, writes logged rather than stored
  always @(posedge clk) begin
    bus.mem_din <= ram_img(bus.mem_a);
    if (bus.mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= bus.mem_a;
      last_wd <= bus.mem_dout;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    last_wa  = '0;
    last_wd  = '0;
    rst      = 1'b1;
    bus.inst_req   = 1'b0;
    bus.inst_addr  = '0;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.data_len   = 2'd0;
    bus.data_addr  = '0;
    bus.data_wdata = '0;

    do_reset();
    check("rst_inst_stat", 64'(bus.inst_stat), 64'd0);
    check("rst_data_stat", 64'(bus.data_stat), 64'd0);
    check("rst_mem_a", 64'(bus.mem_a), 64'd0);
    check("rst_mem_wr", 64'(bus.mem_wr), 64'd0);
    check("rst_mem_dout", 64'(bus.mem_dout), 64'd0);
    check("rst_inst_data", 64'(bus.inst_data), 64'd0);
    check("rst_data_rdata", 64'(bus.data_rdata), 64'd0);
    check("rst_done_addr", 64'(bus.inst_done_addr), 64'd0);

    // Fetch 0x100: BUSY c1..c5, HANDLED c6
    cyc();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h100;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      if (i <= 4) begin
        check("f1_mem_a", 64'(bus.mem_a), 64'(32'h100 + i - 1));
        check("f1_mem_wr", 64'(bus.mem_wr), 64'd0);
      end
      if (i <= 5) check("f1_busy", 64'(bus.inst_stat), 64'd1);
      check("f1_data_idle", 64'(bus.data_stat), 64'd0);
    end
    check("f1_handled", 64'(bus.inst_stat), 64'd2);
    check("f1_inst_data", 64'(bus.inst_data), 64'h0000_0513);
    check("f1_done_addr", 64'(bus.inst_done_addr), 64'h100);
    check("f1_done_mem_a", 64'(bus.mem_a), 64'd0);
    bus.inst_req = 1'b0;
    cyc();
    check("f1_idle", 64'(bus.inst_stat), 64'd0);

    // Byte store 0xAB to 0x30004
    wr_base = wr_cnt;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_len   = 2'd0;
    bus.data_addr  = 32'h30004;
    bus.data_wdata = 32'h1234_56AB;
    cyc();
    check("sb_busy", 64'(bus.data_stat), 64'd1);
    check("sb_mem_wr", 64'(bus.mem_wr), 64'd1);
    check("sb_mem_a", 64'(bus.mem_a), 64'h30004);
    check("sb_mem_dout", 64'(bus.mem_dout), 64'hAB);
    bus.data_req = 1'b0;
    cyc();
    check("sb_handled", 64'(bus.data_stat), 64'd2);
    check("sb_wr_off", 64'(bus.mem_wr), 64'd0);
    cyc();
    check("sb_idle", 64'(bus.data_stat), 64'd0);
    check("sb_wr_count", 64'(wr_cnt - wr_base), 64'd1);
    check("sb_wr_addr", 64'(last_wa), 64'h30004);
    check("sb_wr_byte", 64'(last_wd), 64'hAB);

    // Simultaneous requests from reset: data word load first, then fetch
    do_reset();
    bus.inst_req   = 1'b1;
    bus.inst_addr  = 32'h100;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b0;
    bus.data_len   = 2'd2;
    bus.data_addr  = 32'h200;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check("arb_inst_wait", 64'(bus.inst_stat), 64'd0);
      if (i <= 5) check("arb_data_busy", 64'(bus.data_stat), 64'd1);
    end
    check("arb_data_handled", 64'(bus.data_stat), 64'd2);
    check("arb_data_rdata", 64'(bus.data_rdata), 64'hDEAD_BEEF);
    bus.data_req = 1'b0;
    cyc();
    check("arb_c7_inst_idle", 64'(bus.inst_stat), 64'd0);
    check("arb_c7_data_idle", 64'(bus.data_stat), 64'd0);
    for (int i = 8; i <= 13; i++) begin
      cyc();
      if (i <= 12) check("arb_inst_busy", 64'(bus.inst_stat), 64'd1);
    end
    check("arb_inst_handled", 64'(bus.inst_stat), 64'd2);
    check("arb_inst_data", 64'(bus.inst_data), 64'h0000_0513);
    bus.inst_req = 1'b0;
    cyc();
    check("arb_end_idle", 64'(bus.inst_stat), 64'd0);

    // Half load wrapping the top of the address space
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.data_len  = 2'd1;
    bus.data_addr = 32'hFFFF_FFFF;
    cyc();
    check("wrap_mem_a0", 64'(bus.mem_a), 64'hFFFF_FFFF);
    bus.data_req = 1'b0;
    cyc();
    check("wrap_mem_a1", 64'(bus.mem_a), 64'h0);
    check("wrap_busy", 64'(bus.data_stat), 64'd1);
    cyc();
    check("wrap_busy_c3", 64'(bus.data_stat), 64'd1);
    cyc();
    check("wrap_handled", 64'(bus.data_stat), 64'd2);
    check("wrap_rdata", 64'(bus.data_rdata), 64'h0000_1234);
    cyc();

    // Word store aborted by reset registered at the start of c2
    wr_base = wr_cnt;
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.data_len   = 2'd2;
    bus.data_addr  = 32'h400;
    bus.data_wdata = 32'h1122_3344;
    cyc();
    check("abort_c1_wr", 64'(bus.mem_wr), 64'd1);
    check("abort_c1_dout", 64'(bus.mem_dout), 64'h44);
    bus.data_req = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("abort_c2_wr", 64'(bus.mem_wr), 64'd0);
    check("abort_c2_stat", 64'(bus.data_stat), 64'd0);
    for (int i = 3; i <= 8; i++) begin
      cyc();
      check("abort_no_handled", 64'(bus.data_stat), 64'd0);
      check("abort_wr_low", 64'(bus.mem_wr), 64'd0);
    end
    check("abort_wr_count", 64'(wr_cnt - wr_base), 64'd1);
    check("abort_wr_addr", 64'(last_wa), 64'h400);
    check("abort_wr_byte", 64'(last_wd), 64'h44);

    // Fetch with request dropped and address changed after grant
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h100;
    cyc();
    bus.inst_addr = 32'h200;
    cyc();
    bus.inst_req = 1'b0;
    for (int i = 3; i <= 6; i++) begin
      cyc();
      if (i <= 5) check("drop_busy", 64'(bus.inst_stat), 64'd1);
    end
    check("drop_handled", 64'(bus.inst_stat), 64'd2);
    check("drop_inst_data", 64'(bus.inst_data), 64'h0000_0513);
    check("drop_done_addr", 64'(bus.inst_done_addr), 64'h100);
    cyc();
    check("drop_idle", 64'(bus.inst_stat), 64'd0);
    check("drop_done_hold", 64'(bus.inst_done_addr), 64'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
